// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
// Covers the slice width, the FSM state encoding and the sizing of the slice index.
package multiword_add_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The slice index keeps at least one bit so that WORDS=1 still has a legal vector.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// Shared 16-bit carry-select adder used one slice at a time by the sequencer.
// The upper byte is precomputed for both carry values and selected by the lower byte's carry.
module carry_select_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] sum,
    output logic        Cout
);

    logic [8:0] lo;
    logic [8:0] hi_c0;
    logic [8:0] hi_c1;

    always_comb begin
        lo    = {1'b0, A[7:0]} + {1'b0, B[7:0]} + {8'd0, Cin};
        hi_c0 = {1'b0, A[15:8]} + {1'b0, B[15:8]};
        hi_c1 = {1'b0, A[15:8]} + {1'b0, B[15:8]} + 9'd1;
        sum   = {(lo[8] ? hi_c1[7:0] : hi_c0[7:0]), lo[7:0]};
        Cout  = lo[8] ? hi_c1[8] : hi_c0[8];
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract (16*WORDS bits) performed one 16-bit slice per clock, LSW first,
// through a single shared carry-select adder with the carry chained in a register.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    sub,
    input  logic [WORD_W*WORDS-1:0] A,
    input  logic [WORD_W*WORDS-1:0] B,
    input  logic                    Cin,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    Cout,
    output logic                    overflow
);

    localparam int IDX_W = idx_width(WORDS);
    localparam int TOP   = WORD_W*WORDS - 1;

    state_t                  state;
    state_t                  state_nxt;
    logic                    accept;
    logic                    last;
    logic [IDX_W-1:0]        idx;
    logic [WORD_W*WORDS-1:0] a_reg;
    logic [WORD_W*WORDS-1:0] b_reg;
    logic                    carry_reg;
    logic [WORD_W-1:0]       a_slice;
    logic [WORD_W-1:0]       b_slice;
    logic [WORD_W-1:0]       slice_sum;
    logic                    slice_cout;

    // Signed overflow: same-sign operands whose result sign flips. b_reg is already
    // inverted in subtract mode, so one rule covers both operations.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign accept = start && (state != RUN);
    assign last   = (idx == IDX_W'(WORDS - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                a_slice = a_reg[w*WORD_W +: WORD_W];
                b_slice = b_reg[w*WORD_W +: WORD_W];
            end
        end
    end

    carry_select_16bit u_adder (
        .A    (a_slice),
        .B    (b_slice),
        .Cin  (carry_reg),
        .sum  (slice_sum),
        .Cout (slice_cout)
    );

    // Operand capture on accept, then one slice retired per RUN clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            Cout      <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            a_reg     <= A;
            b_reg     <= sub ? ~B : B;
            carry_reg <= sub ? 1'b1 : Cin;
        end else if (state == RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx == IDX_W'(w)) begin
                    sum[w*WORD_W +: WORD_W] <= slice_sum;
                end
            end
            carry_reg <= slice_cout;
            idx       <= idx + IDX_W'(1);
            if (last) begin
                Cout     <= slice_cout;
                overflow <= signed_ovf(a_reg[TOP], b_reg[TOP], slice_sum[WORD_W-1]);
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed and randomized checks of the multi-word sequencer (WORDS=4 and WORDS=1)
// against a plain-arithmetic reference model.
module tb_multiword_add_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, sub, Cin;
    logic [63:0] A, B;
    logic        busy, done, Cout, overflow;
    logic [63:0] sum;

    logic        start1, sub1, Cin1;
    logic [15:0] a1, b1;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] sum1;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_sum;
    logic        exp_cout, exp_ovf;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.WORDS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .sum(sum), .Cout(Cout), .overflow(overflow)
    );

    multiword_add_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub1), .A(a1), .B(b1), .Cin(Cin1),
        .busy(busy1), .done(done1), .sum(sum1), .Cout(cout1), .overflow(ovf1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain modulo arithmetic of width n; Cout is carry (add) or no-borrow (sub).
    task automatic model(input int n, input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic c, output logic [63:0] r, output logic co, output logic ov);
        logic [64:0] full;
        logic [63:0] mask;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        a = a & mask;
        b = b & mask;
        if (!s) begin
            full = {1'b0, a} + {1'b0, b} + {64'd0, c};
            r    = full[63:0] & mask;
            co   = (n == 64) ? full[64] : full[n];
            ov   = (a[n-1] == b[n-1]) && (r[n-1] != a[n-1]);
        end else begin
            r  = (a - b) & mask;
            co = (a >= b);
            ov = (a[n-1] != b[n-1]) && (r[n-1] != a[n-1]);
        end
    endtask

    // Present an op for one edge; called at #1 after a rising edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic c);
        A = a; B = b; sub = s; Cin = c; start = 1'b1;
        model(64, a, b, s, c, exp_sum, exp_cout, exp_ovf);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done, then checks latency, busy duration and results.
    task automatic wait_check(input string tag, input int exp_lat);
        int n;
        int bc;
        n = 0;
        bc = 0;
        while (!done && n < 40) begin
            bc += int'(busy);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busycycles"}, 64'(bc), 64'(exp_lat));
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, 64'(Cout), 64'(exp_cout));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clk); #1;
        check({tag, "_donepulse"}, 64'(done), 64'd0);
        check({tag, "_heldsum"}, sum, exp_sum);
    endtask

    initial begin
        logic [63:0] ra, rb, r1;
        logic        rs, rc, co1, ov1;
        int          n;
        int          seen;

        reset = 1'b1; start = 1'b0; sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
        start1 = 1'b0; sub1 = 1'b0; Cin1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", 64'(Cout), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_sum_w1", 64'(sum1), 64'd0);

        issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        check("wordcarry_model", exp_sum, 64'h0000_0000_0001_0000);
        wait_check("wordcarry", 4);
        pulse_end("wordcarry");

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
        wait_check("ripple", 4);
        check("ripple_cout_const", 64'(Cout), 64'd1);

        issue(64'd5, 64'd7, 1'b1, 1'b0);
        wait_check("sub_borrow", 4);
        check("sub_borrow_const", sum, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(64'd7, 64'd5, 1'b1, 1'b1);
        wait_check("sub_noborrow", 4);
        check("sub_noborrow_const", sum, 64'd2);

        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        wait_check("ovf", 4);
        check("ovf_const", 64'(overflow), 64'd1);

        // start during RUN with other operands must be ignored.
        issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        A = 64'hDEAD_BEEF_0000_0001; B = 64'h5; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_check("ignore_start", 2);

        // start held in DONE: back-to-back accept.
        issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1);
        wait_check("b2b_first", 4);
        issue(64'h0000_0001_0000_0000, 64'h1, 1'b1, 1'b0);
        wait_check("b2b_second", 4);

        // Reset during slice 2: abort, clear, no done.
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        wait_check("pre_reset", 4);
        issue(64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", sum, 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            seen += int'(done) + int'(busy);
            @(posedge clk); #1;
        end
        check("abort_quiet", 64'(seen), 64'd0);

        for (int t = 0; t < 20; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (t % 5 == 0) rb = ra;
            if (t % 7 == 3) ra = {1'b0, {63{1'b1}}};
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, rc);
            wait_check($sformatf("rand%0d", t), 4);
        end

        // WORDS=1 corner.
        a1 = 16'hFFFF; b1 = 16'h0001; sub1 = 1'b0; Cin1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("w1_latency", 64'(n), 64'd1);
        check("w1_sum", 64'(sum1), 64'd0);
        check("w1_cout", 64'(cout1), 64'd1);
        for (int t = 0; t < 6; t++) begin
            a1 = 16'($urandom); b1 = 16'($urandom);
            sub1 = 1'($urandom_range(0, 1)); Cin1 = 1'($urandom_range(0, 1));
            model(16, {48'd0, a1}, {48'd0, b1}, sub1, Cin1, r1, co1, ov1);
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            n = 0;
            while (!done1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("w1_rand%0d_lat", t), 64'(n), 64'd1);
            check($sformatf("w1_rand%0d_sum", t), 64'(sum1), r1);
            check($sformatf("w1_rand%0d_cout", t), 64'(cout1), 64'(co1));
            check($sformatf("w1_rand%0d_ovf", t), 64'(ovf1), 64'(ov1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-cycle sequencer that performs wide add/subtract (16*WORDS bits) by reusing a single 16-bit carry-select adder, one 16-bit word per clock, LSW first.
- Latches the operands, drives the adder slice by slice, and chains the carry through a register between slices.
- Collects the result and reports completion with a one-cycle pulse.
- Sits between a host/control FSM and the shared adder datapath in the arithmetic unit.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width is 16*WORDS (default 64 bits). Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- sub  input  1  0 = A+B+Cin, 1 = A-B (Cin ignored)
- A  input  16*WORDS  operand A; sampled on the start-accept edge
- B  input  16*WORDS  operand B; sampled on the start-accept edge
- Cin  input  1  carry-in for add mode
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse; result valid
- sum  output  16*WORDS  result; held until the next accepted start
- Cout  output  1  final carry-out (borrow-not for sub)
- overflow  output  1  two's-complement signed overflow of the full-width result

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-high (reset).
- States: IDLE, RUN, DONE.
  - IDLE: wait for start.
  - RUN: one slice per clock, for WORDS clocks.
  - DONE: exactly one clock, then IDLE.
- Accept: start=1 while in IDLE or DONE (back-to-back allowed). At the accept edge:
  - Latch A into the operand-A register.
  - Latch sub ? ~B : B into the operand-B register.
  - Set the carry register to sub ? 1 : Cin.
  - Clear the slice index to 0; go to RUN.
- start while in RUN is ignored; operands are not resampled.
- RUN, slice i (per clock):
  - Adder inputs: A_reg[16i+15:16i], B_reg[16i+15:16i], carry_reg.
  - At the edge: write the adder sum to sum[16i+15:16i]; carry_reg <= adder cout; i <= i+1.
  - When i == WORDS-1, go to DONE.
- Latency: done is high in the cycle after the WORDS-th RUN edge, i.e. it is first sampled high WORDS+1 edges after the accept edge. WORDS=1 gives one RUN cycle, then DONE.
- DONE: done=1 and busy=0; Cout = carry_reg.
- overflow = (A_reg MSB == B_reg-effective MSB) && (sum MSB != A_reg MSB), registered at the last slice.
- busy = (state == RUN). done = (state == DONE).
- sum, Cout and overflow are stable from DONE until the next accept edge.
  - sum is partially overwritten during the next RUN; consumers must sample it on done.
- Reset values: state IDLE, busy 0, done 0, sum 0, Cout 0, overflow 0, index 0, carry_reg 0.
- Reset asserted mid-RUN: abort at that edge. No done pulse; outputs are cleared. reset has priority over start.
- Arithmetic is modulo 2^(16*WORDS). In sub mode, Cout=1 means no borrow (A >= B unsigned).

Decomposition:
- Shared package holds:
  - WORD_W = 16.
  - State enum {IDLE, RUN, DONE}.
  - Index width = clog2(WORDS), minimum 1.
- One sub-module: the existing 16-bit carry-select adder (carry_select_16bit), instantiated once with its A/B/Cin/sum/Cout mapped to the current slice.
- No other hierarchy.

Test Plan:
- Word-boundary carry (WORDS=4, add): A=0x0000_0000_0000_FFFF, B=0x1, Cin=0 -> sum=0x0000_0000_0001_0000, Cout=0, overflow=0, done exactly 5 edges after accept, busy high for 4 cycles.
- Full ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x0, Cin=1 -> sum=0, Cout=1, overflow=0.
- Subtract with borrow: sub=1, A=5, B=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, Cout=0, overflow=0. Repeat with A=7, B=5 -> sum=2, Cout=1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> sum=0x8000_0000_0000_0000, overflow=1, Cout=0.
- Protocol:
  - start pulsed during RUN with different operands -> ignored, first result unchanged.
  - start held during DONE -> new op accepted, second done 5 edges later.
  - reset asserted at RUN slice 2 -> next cycle state IDLE, sum=0, no done pulse.
- Parameter corner: WORDS=1, A=0xFFFF, B=1 -> sum=0, Cout=1, done 2 edges after accept.
